// File: rtl/mby_gmm_pkg.sv
// Shared GMM north types: pod pointer, ring slot, dirty-pod injector FSM state and defaults.
package mby_gmm_pkg;

  localparam int MBY_POD_PTR_W          = 20;
  localparam int MBY_POD_INJ_FIFO_DEPTH = 16;
  localparam int MBY_POD_INJ_STARVE_CYC = 64;

  typedef logic [MBY_POD_PTR_W-1:0] mby_pod_ptr_t;

  typedef struct packed {
    logic         valid;
    mby_pod_ptr_t ptr;
  } mby_pod_ring_slot_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    STALLED = 2'd2
  } mby_pod_inj_state_t;

endpackage

// File: rtl/mby_gmm_dirty_pod_inj_if.sv
// Dirty-pod push channel plus pod pointer ring input/output slots.
interface mby_gmm_dirty_pod_inj_if
  import mby_gmm_pkg::*;
#(
  parameter int POD_PTR_W = MBY_POD_PTR_W
);

  // dp_*: a pointer transfers on a cycle where dp_valid && dp_ready; dp_ptr must be
  // stable while dp_valid is high. The ring has no backpressure: a slot moves every cycle.
  logic                 dp_valid;
  logic [POD_PTR_W-1:0] dp_ptr;
  logic                 dp_ready;
  logic                 ring_in_valid;
  logic [POD_PTR_W-1:0] ring_in_ptr;
  logic                 ring_out_valid;
  logic [POD_PTR_W-1:0] ring_out_ptr;

  modport master (
    output dp_valid, dp_ptr, ring_in_valid, ring_in_ptr,
    input  dp_ready, ring_out_valid, ring_out_ptr
  );

  modport slave (
    input  dp_valid, dp_ptr, ring_in_valid, ring_in_ptr,
    output dp_ready, ring_out_valid, ring_out_ptr
  );

endinterface

// File: rtl/mby_gmm_pod_fifo.sv
// Flop FIFO for dirty pod pointers; DEPTH is a power of 2 so pointers wrap naturally.
module mby_gmm_pod_fifo #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Caller guarantees push only when not full and pop only when not empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/mby_gmm_dirty_pod_inj.sv
// Injects buffered dirty pod pointers into empty slots of the GMM north pod ring.
// Optional MBY_GMM_POD_INJ_STATS_EN adds injection and stall-cycle counters.
module mby_gmm_dirty_pod_inj
  import mby_gmm_pkg::*;
#(
  parameter int POD_PTR_W  = MBY_POD_PTR_W,
  parameter int FIFO_DEPTH = MBY_POD_INJ_FIFO_DEPTH,
  parameter int STARVE_CYC = MBY_POD_INJ_STARVE_CYC
) (
  input  logic                        cclk,
  input  logic                        reset,
  input  logic                        pod_ring_stall_in,
  mby_gmm_dirty_pod_inj_if.slave      bus,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        starve_alert,
  output mby_pod_inj_state_t          state_dbg
`ifdef MBY_GMM_POD_INJ_STATS_EN
  ,
  output logic [31:0]                 inj_cnt,
  output logic [31:0]                 stall_cyc_cnt
`endif
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int CW = $clog2(STARVE_CYC + 1);
  localparam logic [LW-1:0] FULL_LVL   = LW'(FIFO_DEPTH);
  localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE_CYC);

  logic                 dp_ready;
  logic                 push;
  logic                 pop;
  logic [POD_PTR_W-1:0] head;
  logic [LW-1:0]        level_nxt;
  mby_pod_inj_state_t   state_q;
  mby_pod_inj_state_t   state_nxt;
  logic [CW-1:0]        starve_q;
  logic [CW-1:0]        starve_nxt;
  logic                 out_valid_q;
  logic [POD_PTR_W-1:0] out_ptr_q;

  assign dp_ready = (fifo_level != FULL_LVL);
  assign push     = bus.dp_valid && dp_ready;
  // Head is read from the registered level, so a fresh push cannot bypass to the ring.
  assign pop      = !bus.ring_in_valid && (fifo_level != '0) && !pod_ring_stall_in;

  mby_gmm_pod_fifo #(
    .WIDTH (POD_PTR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (cclk),
    .rst       (reset),
    .push      (push),
    .push_data (bus.dp_ptr),
    .pop       (pop),
    .head      (head),
    .level     (fifo_level)
  );

  always_comb begin
    level_nxt = fifo_level;
    if (push && !pop)      level_nxt = fifo_level + 1'b1;
    else if (pop && !push) level_nxt = fifo_level - 1'b1;

    state_nxt = ARMED;
    if (level_nxt == '0)        state_nxt = IDLE;
    else if (pod_ring_stall_in) state_nxt = STALLED;

    starve_nxt = starve_q;
    if (pop || state_nxt == IDLE)                        starve_nxt = '0;
    else if (state_q != IDLE && starve_q != STARVE_MAX)  starve_nxt = starve_q + 1'b1;
  end

  always_ff @(posedge cclk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      starve_q     <= '0;
      starve_alert <= 1'b0;
      out_valid_q  <= 1'b0;
      out_ptr_q    <= '0;
    end else begin
      state_q      <= state_nxt;
      starve_q     <= starve_nxt;
      starve_alert <= (starve_nxt == STARVE_MAX);
      if (bus.ring_in_valid) begin
        out_valid_q <= 1'b1;
        out_ptr_q   <= bus.ring_in_ptr;
      end else if (pop) begin
        out_valid_q <= 1'b1;
        out_ptr_q   <= head;
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

`ifdef MBY_GMM_POD_INJ_STATS_EN
  always_ff @(posedge cclk or posedge reset) begin
    if (reset) begin
      inj_cnt       <= '0;
      stall_cyc_cnt <= '0;
    end else begin
      if (pop)                inj_cnt       <= inj_cnt + 1'b1;
      if (state_q == STALLED) stall_cyc_cnt <= stall_cyc_cnt + 1'b1;
    end
  end
`else
  // Without the stats build there is no counter state at all.
`endif

  assign bus.dp_ready       = dp_ready;
  assign bus.ring_out_valid = out_valid_q;
  assign bus.ring_out_ptr   = out_ptr_q;
  assign state_dbg          = state_q;

endmodule
